// File: rtl/instr_register_sequencer.sv
// Instruction register sequencer: loads producer instructions into an external register file
// and replays them in order to a consumer. Define INSTR_SEQ_CHECK_EN to enable the result checker.
package instr_seq_pkg;
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t            opc;
    logic signed [31:0] op_a;
    logic signed [31:0] op_b;
    logic signed [63:0] result;
  } instruction_t;
endpackage

module instr_register_sequencer
  import instr_seq_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               push_valid,
  output logic               push_ready,
  input  opcode_t            push_opcode,
  input  logic signed [31:0] push_operand_a,
  input  logic signed [31:0] push_operand_b,
  output logic               load_en,
  output logic [4:0]         write_pointer,
  output logic [4:0]         read_pointer,
  output logic signed [31:0] operand_a,
  output logic signed [31:0] operand_b,
  output opcode_t            opcode,
  input  instruction_t       instruction_word,
  output logic               pop_valid,
  input  logic               pop_ready,
  output opcode_t            pop_opcode,
  output logic signed [31:0] pop_operand_a,
  output logic signed [31:0] pop_operand_b,
  output logic signed [63:0] pop_result,
  output logic [5:0]         count,
  output logic               err_flag,
  output logic [7:0]         err_count,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAPT = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [4:0] PTR_LAST = 5'(DEPTH - 1);
  localparam logic [5:0] CNT_FULL = 6'(DEPTH);

  state_t     state, state_next;
  logic [4:0] wr_ptr, rd_ptr;
  logic       push_accept, capt_done, pop_fire;

  // Handshakes: a push transfers on a rising edge with push_valid && push_ready, a pop on a
  // rising edge with pop_valid && pop_ready; pop_* stay stable while pop_valid waits for ready.
  assign push_ready    = reset_n & ~flush & (count < CNT_FULL);
  assign push_accept   = push_valid & push_ready;
  assign load_en       = push_accept;
  assign operand_a     = push_operand_a;
  assign operand_b     = push_operand_b;
  assign opcode        = push_opcode;
  assign write_pointer = wr_ptr;
  assign read_pointer  = rd_ptr;
  assign capt_done     = (state == CAPT);
  assign pop_fire      = pop_valid & pop_ready;
  assign dbg_state     = state;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (count != 6'd0 && !pop_valid) state_next = CAPT;
      CAPT: state_next = HOLD;
      HOLD: if (pop_ready) state_next = (count != 6'd0) ? CAPT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      pop_valid     <= 1'b0;
      pop_opcode    <= ZERO;
      pop_operand_a <= '0;
      pop_operand_b <= '0;
      pop_result    <= '0;
    end else if (flush) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (push_accept) wr_ptr <= (wr_ptr == PTR_LAST) ? 5'd0 : wr_ptr + 5'd1;
      if (capt_done) begin
        rd_ptr        <= (rd_ptr == PTR_LAST) ? 5'd0 : rd_ptr + 5'd1;
        pop_opcode    <= instruction_word.opc;
        pop_operand_a <= instruction_word.op_a;
        pop_operand_b <= instruction_word.op_b;
        pop_result    <= instruction_word.result;
        pop_valid     <= 1'b1;
      end else if (pop_fire) begin
        pop_valid <= 1'b0;
      end
      // count tracks entries written but not yet captured into the pop registers
      case ({push_accept, capt_done})
        2'b10:   count <= count + 6'd1;
        2'b01:   count <= count - 6'd1;
        default: count <= count;
      endcase
    end
  end

`ifdef INSTR_SEQ_CHECK_EN
  function automatic logic signed [63:0] expected_result(input instruction_t w);
    logic signed [63:0] a;
    logic signed [63:0] b;
    logic signed [63:0] r;
    a = {{32{w.op_a[31]}}, w.op_a};
    b = {{32{w.op_b[31]}}, w.op_b};
    case (w.opc)
      ZERO:    r = 64'sd0;
      PASSA:   r = a;
      PASSB:   r = b;
      ADD:     r = a + b;
      SUB:     r = a - b;
      MULT:    r = a * b;
      DIV:     r = (b == 64'sd0) ? 64'sd0 : a / b;
      MOD:     r = (b == 64'sd0) ? 64'sd0 : a % b;
      default: r = 64'sd0;
    endcase
    return r;
  endfunction

  // Error state survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      err_flag  <= 1'b0;
      err_count <= 8'd0;
    end else if (capt_done && !flush &&
                 (expected_result(instruction_word) != instruction_word.result)) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_flag  = 1'b0;
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_instr_register_sequencer.sv
// Directed bench for instr_register_sequencer with a behavioural instruction register.
// Expected error counts follow INSTR_SEQ_CHECK_EN when the build defines it.
module tb_instr_register_sequencer;
  import instr_seq_pkg::*;

  logic               clk;
  logic               reset_n;
  logic               flush;
  logic               push_valid;
  logic               push_ready;
  opcode_t            push_opcode;
  logic signed [31:0] push_operand_a;
  logic signed [31:0] push_operand_b;
  logic               load_en;
  logic [4:0]         write_pointer;
  logic [4:0]         read_pointer;
  logic signed [31:0] operand_a;
  logic signed [31:0] operand_b;
  opcode_t            opcode;
  instruction_t       instruction_word;
  logic               pop_valid;
  logic               pop_ready;
  opcode_t            pop_opcode;
  logic signed [31:0] pop_operand_a;
  logic signed [31:0] pop_operand_b;
  logic signed [63:0] pop_result;
  logic [5:0]         count;
  logic               err_flag;
  logic [7:0]         err_count;
  logic [1:0]         dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // instruction register model: stores the result supplied with each push
  instruction_t   mem [32];
  longint         pending_result;
  bit             corrupt;
  bit             last_ok;
  logic           last_le;
  logic [4:0]     last_wp;
  logic [7:0]     err_before;
  logic           flag_before;
  logic [7:0]     exp_err_count;
  logic           exp_err_flag;

  instr_register_sequencer #(.DEPTH(32)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .flush            (flush),
    .push_valid       (push_valid),
    .push_ready       (push_ready),
    .push_opcode      (push_opcode),
    .push_operand_a   (push_operand_a),
    .push_operand_b   (push_operand_b),
    .load_en          (load_en),
    .write_pointer    (write_pointer),
    .read_pointer     (read_pointer),
    .operand_a        (operand_a),
    .operand_b        (operand_b),
    .opcode           (opcode),
    .instruction_word (instruction_word),
    .pop_valid        (pop_valid),
    .pop_ready        (pop_ready),
    .pop_opcode       (pop_opcode),
    .pop_operand_a    (pop_operand_a),
    .pop_operand_b    (pop_operand_b),
    .pop_result       (pop_result),
    .count            (count),
    .err_flag         (err_flag),
    .err_count        (err_count),
    .dbg_state        (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction_word = mem[read_pointer];

  always @(posedge clk) begin
    if (load_en)
      mem[write_pointer] <= '{opc: opcode, op_a: operand_a, op_b: operand_b,
                              result: pending_result + (corrupt ? 64'sd1 : 64'sd0)};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // driver tasks
  task automatic do_reset();
    reset_n    = 1'b0;
    push_valid = 1'b0;
    pop_ready  = 1'b0;
    flush      = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic push_one(input opcode_t opc, input int a, input int b, input longint res);
    push_valid     = 1'b1;
    push_opcode    = opc;
    push_operand_a = a;
    push_operand_b = b;
    pending_result = res;
    last_ok        = 1'b0;
    for (int i = 0; i < 64 && !last_ok; i++) begin
      #1;
      if (push_ready) begin
        last_ok = 1'b1;
        last_le = load_en;
        last_wp = write_pointer;
      end else begin
        tick();
      end
    end
    if (!last_ok) check_eq("push_timeout", 64'(last_ok), 64'd1);
    tick();
    push_valid = 1'b0;
  endtask

  task automatic pop_one(input string tag, input int exp_a, input longint exp_res);
    bit seen;
    seen      = 1'b0;
    pop_ready = 1'b1;
    for (int i = 0; i < 64 && !seen; i++) begin
      #1;
      if (pop_valid) seen = 1'b1;
      else tick();
    end
    check_eq({tag, "_valid"}, 64'(pop_valid), 64'd1);
    check_eq({tag, "_a"}, 64'(pop_operand_a), 64'(exp_a));
    check_eq({tag, "_res"}, pop_result, exp_res);
    tick();
    pop_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    corrupt        = 1'b0;
    pending_result = 0;
    push_opcode    = ZERO;
    push_operand_a = 0;
    push_operand_b = 0;

    // reset: push attempt must be held off
    reset_n        = 1'b0;
    flush          = 1'b0;
    pop_ready      = 1'b0;
    push_valid     = 1'b1;
    push_opcode    = ADD;
    push_operand_a = 1;
    tick();
    #1;
    check_eq("rst_push_ready", 64'(push_ready), 64'd0);
    check_eq("rst_load_en", 64'(load_en), 64'd0);
    tick();
    push_valid = 1'b0;
    reset_n    = 1'b1;
    #1;
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_pop_valid", 64'(pop_valid), 64'd0);
    check_eq("rst_rd_ptr", 64'(read_pointer), 64'd0);
    check_eq("rst_wr_ptr", 64'(write_pointer), 64'd0);
    check_eq("rst_pop_result", pop_result, 64'd0);
    check_eq("rst_err_count", 64'(err_count), 64'd0);
    check_eq("rst_push_ready_hi", 64'(push_ready), 64'd1);
    tick();

    // single ADD 5+3: three-cycle latency to pop_valid
    push_one(ADD, 5, 3, 8);
    check_eq("add_load_en", 64'(last_le), 64'd1);
    check_eq("add_wr_ptr", 64'(last_wp), 64'd0);
    check_eq("add_count_n1", 64'(count), 64'd1);
    check_eq("add_pv_n1", 64'(pop_valid), 64'd0);
    tick();
    check_eq("add_pv_n2", 64'(pop_valid), 64'd0);
    tick();
    check_eq("add_pv_n3", 64'(pop_valid), 64'd1);
    check_eq("add_opcode", 64'(pop_opcode), 64'(ADD));
    check_eq("add_result", pop_result, 64'd8);
    check_eq("add_count_n3", 64'(count), 64'd0);
    pop_ready = 1'b1;
    tick();
    pop_ready = 1'b0;
    check_eq("add_pv_after_pop", 64'(pop_valid), 64'd0);

    // fill with pop_ready low: one entry sits in the pop registers, so 33 are accepted
    for (int k = 0; k < 33; k++) begin
      push_one(PASSA, 100 + k, k, 100 + k);
      check_eq("fill_accept", 64'(last_ok), 64'd1);
    end
    check_eq("full_count", 64'(count), 64'd32);
    push_valid     = 1'b1;
    push_opcode    = PASSA;
    push_operand_a = 999;
    pending_result = 999;
    #1;
    check_eq("full_push_ready", 64'(push_ready), 64'd0);
    check_eq("full_load_en", 64'(load_en), 64'd0);
    tick();
    push_valid = 1'b0;
    check_eq("full_count_hold", 64'(count), 64'd32);
    for (int k = 0; k < 33; k++) pop_one("drain", 100 + k, 100 + k);
    check_eq("drain_count", 64'(count), 64'd0);
    check_eq("drain_pv", 64'(pop_valid), 64'd0);

    // wrap: 40 pushes with concurrent draining
    do_reset();
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          push_one(ADD, k, 1000, 1000 + k);
          check_eq("wrap_wp", 64'(last_wp), 64'(k % 32));
        end
      end
      begin
        for (int k = 0; k < 40; k++) pop_one("wrap", k, 1000 + k);
      end
    join
    check_eq("wrap_count", 64'(count), 64'd0);

    // divide and modulo corner cases
    push_one(DIV, 7, 0, 0);
    push_one(MOD, -7, 2, -1);
    pop_one("div0", 7, 0);
    pop_one("mod", -7, -1);
    check_eq("divmod_err_flag", 64'(err_flag), 64'd0);
    check_eq("divmod_err_count", 64'(err_count), 64'd0);

    // register returns result + 1 for three instructions
    corrupt = 1'b1;
    push_one(MULT, -3, 4, -12);
    push_one(MULT, 6, 7, 42);
    push_one(PASSB, 1, 9, 9);
    corrupt = 1'b0;
    pop_one("bad_mult1", -3, -11);
    pop_one("bad_mult2", 6, 43);
    pop_one("bad_passb", 1, 10);
`ifdef INSTR_SEQ_CHECK_EN
    exp_err_count = 8'd3;
    exp_err_flag  = 1'b1;
`else
    exp_err_count = 8'd0;
    exp_err_flag  = 1'b0;
`endif
    check_eq("chk_err_count", 64'(err_count), 64'(exp_err_count));
    check_eq("chk_err_flag", 64'(err_flag), 64'(exp_err_flag));

    // flush with one held entry and one queued entry
    push_one(SUB, 10, 4, 6);
    push_one(SUB, 20, 5, 15);
    tick();
    check_eq("pre_flush_count", 64'(count), 64'd1);
    check_eq("pre_flush_pv", 64'(pop_valid), 64'd1);
    err_before  = err_count;
    flag_before = err_flag;
    flush       = 1'b1;
    push_valid  = 1'b1;
    #1;
    check_eq("flush_push_ready", 64'(push_ready), 64'd0);
    tick();
    flush      = 1'b0;
    push_valid = 1'b0;
    check_eq("flush_count", 64'(count), 64'd0);
    check_eq("flush_pv", 64'(pop_valid), 64'd0);
    check_eq("flush_wr_ptr", 64'(write_pointer), 64'd0);
    check_eq("flush_rd_ptr", 64'(read_pointer), 64'd0);
    check_eq("flush_err_count", 64'(err_count), 64'(err_before));
    check_eq("flush_err_flag", 64'(err_flag), 64'(flag_before));
    check_eq("flush_err_exp", 64'(err_count), 64'(exp_err_count));

    // reset mid-operation with count = 5 and pop_valid = 1
    for (int k = 0; k < 6; k++) push_one(PASSA, 50 + k, 0, 50 + k);
    check_eq("mid_count", 64'(count), 64'd5);
    check_eq("mid_pv", 64'(pop_valid), 64'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_eq("mid_rst_count", 64'(count), 64'd0);
    check_eq("mid_rst_pv", 64'(pop_valid), 64'd0);
    check_eq("mid_rst_err", 64'(err_count), 64'd0);
    push_one(ADD, 2, 2, 4);
    check_eq("mid_rst_wp", 64'(last_wp), 64'd0);
    pop_one("post_rst", 2, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
